// File: rtl/dsp_operand_slave_if.sv
// Wishbone classic bus bundle between an initiator and the DSP operand slave.
interface dsp_operand_slave_if #(
  parameter int AW = 6
);
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/dsp_operand_slave.sv
// Wishbone slave holding DSP operand RAM plus a CTRL/STAT word at the top address.
// Define DSP_OPERAND_SLAVE_ERR_EN to terminate sel==0 and start-while-busy transfers with err.
module dsp_operand_slave #(
  parameter int AW          = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  dsp_operand_slave_if.slave  wb,
  output logic                dsp_start_o,
  input  logic                dsp_done_i
);

  localparam logic [AW-1:0] CTRL_ADR = '1;
  localparam logic [3:0]    WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   mem_q [2**AW];

  logic          is_ctrl;
  logic          start_req;
  logic          err_cond;
  logic          resp;
  logic          commit;
  logic [3:0]    mem_lane_we;
  logic [31:0]   rdata;

  always_comb begin
    is_ctrl   = (adr_q == CTRL_ADR);
    start_req = we_q & is_ctrl & sel_q[0] & dat_q[0];
`ifdef DSP_OPERAND_SLAVE_ERR_EN
    err_cond  = (sel_q == 4'b0000) | (start_req & busy_q);
`else
    err_cond  = 1'b0;
`endif
    resp      = (state_q == RESP);
    commit    = resp & we_q & ~err_cond;
    rdata     = is_ctrl ? {30'd0, done_q, busy_q} : mem_q[adr_q];

    wb.wb_ack_o = resp & ~err_cond;
    wb.wb_err_o = resp & err_cond;
    wb.wb_dat_o = (wb.wb_ack_o & ~we_q) ? rdata : 32'd0;
    dsp_start_o = start_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    busy_d      = busy_q;
    done_d      = done_q;
    start_d     = 1'b0;
    mem_lane_we = 4'b0000;

    case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          adr_d = wb.wb_adr_i;
          we_d  = wb.wb_we_i;
          sel_d = wb.wb_sel_i;
          dat_d = wb.wb_dat_i;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // Initiator abandoning the cycle discards the latched transfer.
        if (!wb.wb_cyc_i)     state_d = IDLE;
        else if (cnt_q == 0)  state_d = RESP;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (dsp_done_i) busy_d = 1'b0;

    if (commit) begin
      if (is_ctrl) begin
        if (sel_q[0]) begin
          if (dat_q[0] && !busy_q) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
          if (dat_q[1]) done_d = 1'b0;
        end
      end else begin
        mem_lane_we = sel_q;
      end
    end

    // Completion arriving alongside a clear keeps the flag set.
    if (dsp_done_i) done_d = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    adr_q <= adr_d;
    we_q  <= we_d;
    sel_q <= sel_d;
    dat_q <= dat_d;
    for (int i = 0; i < 4; i++) begin
      if (mem_lane_we[i]) mem_q[adr_q][8*i +: 8] <= dat_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dsp_operand_slave.sv
// Scoreboard bench for dsp_operand_slave: read expectations queued at issue, checked at ack.
module tb_dsp_operand_slave;
  localparam int AW = 6;
  localparam int WS = 1;
  localparam logic [AW-1:0] CTRL = '1;
`ifdef DSP_OPERAND_SLAVE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  logic dsp_start_o;
  logic dsp_done_i = 1'b0;

  dsp_operand_slave_if #(.AW(AW)) bus();

  dsp_operand_slave #(.AW(AW), .WAIT_STATES(WS)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb          (bus.slave),
    .dsp_start_o (dsp_start_o),
    .dsp_done_i  (dsp_done_i)
  );

  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cycles = 0;
  logic [31:0] exp_q [$];

  always @(negedge wb_clk) if (dsp_start_o === 1'b1) start_cycles++;

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  end

  task automatic xfer(input logic [AW-1:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_rd, input logic exp_err,
                      input logic done_at_resp, input string name);
    int lat;
    logic got_ack, got_err;
    logic [31:0] exp;
    if (!we) exp_q.push_back(exp_rd);
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (lat < 20 && got_ack !== 1'b1 && got_err !== 1'b1) begin
      @(posedge wb_clk); #1;
      lat++;
      got_ack = bus.wb_ack_o;
      got_err = bus.wb_err_o;
    end
    n_cmp++;
    if (got_ack !== 1'b1 && got_err !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: no ack/err after %0d cycles, required within %0d", name, lat, WS + 1);
      if (!we) void'(exp_q.pop_front());
    end else begin
      if (lat != WS + 1) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, WS + 1);
      end
      n_cmp++;
      if (got_ack !== !exp_err || got_err !== exp_err) begin
        n_bad++;
        $display("FAIL %s_term: ack=%b err=%b, required ack=%b err=%b", name, got_ack, got_err, !exp_err, exp_err);
      end
      if (!we) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.wb_dat_o !== exp) begin
          n_bad++;
          $display("FAIL %s_rdata: got %h, required %h", name, bus.wb_dat_o, exp);
        end
      end
    end
    if (done_at_resp) dsp_done_i = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge wb_clk); #1;
    dsp_done_i = 1'b0;
    n_cmp++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_width: ack=%b err=%b one cycle later, required 0 0", name, bus.wb_ack_o, bus.wb_err_o);
    end
  endtask

  task automatic pulse_done();
    @(posedge wb_clk); #1;
    dsp_done_i = 1'b1;
    @(posedge wb_clk); #1;
    dsp_done_i = 1'b0;
  endtask

  task automatic check_start_delta(input int s0, input int exp, input string name);
    repeat (3) @(posedge wb_clk);
    #1;
    n_cmp++;
    if (start_cycles - s0 != exp) begin
      n_bad++;
      $display("FAIL %s: start high for %0d cycles, required %0d", name, start_cycles - s0, exp);
    end
  endtask

  task automatic test_reset();
    #1 wb_rst = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    n_cmp++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'd0 || dsp_start_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ack=%b err=%b dat=%h start=%b, required 0 0 0 0",
               bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, dsp_start_o);
    end
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "reset_stat");
    for (int a = 0; a < 8; a++) xfer(AW'(a), 1'b1, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "preload");
  endtask

  task automatic test_write_read();
    xfer(6'd3, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, "wr3");
    xfer(6'd3, 1'b0, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, "rd3");
  endtask

  task automatic test_byte_lanes();
    xfer(6'd5, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0, "lane_full");
    xfer(6'd5, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b0, "lane_part");
    xfer(6'd5, 1'b0, 32'd0, 4'hF, 32'h11BB33DD, 1'b0, 1'b0, "lane_rd");
  endtask

  task automatic test_start_done();
    int s0;
    s0 = start_cycles;
    xfer(CTRL, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, "start_wr");
    check_start_delta(s0, 1, "start_pulse");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h1, 1'b0, 1'b0, "stat_busy");
    pulse_done();
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h2, 1'b0, 1'b0, "stat_done");
    xfer(CTRL, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b0, "done_clr");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "stat_clr");
  endtask

  task automatic test_start_while_busy();
    int s0;
    s0 = start_cycles;
    xfer(CTRL, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, "sb_first");
    xfer(CTRL, 1'b1, 32'h1, 4'hF, 32'h0, ERR_EN, 1'b0, "sb_second");
    check_start_delta(s0, 1, "sb_pulses");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h1, 1'b0, 1'b0, "sb_stat");
    xfer(CTRL, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b1, "set_wins_wr");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h2, 1'b0, 1'b0, "set_wins_stat");
    xfer(CTRL, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b0, "set_wins_clr");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "set_wins_stat0");
  endtask

  task automatic test_abort();
    int acks;
    acks = 0;
    bus.wb_adr_i = 6'd7;
    bus.wb_dat_i = 32'h55;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    repeat (4) begin
      @(posedge wb_clk); #1;
      if (bus.wb_ack_o !== 1'b0) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL abort_ack: saw %0d ack cycles, required 0", acks);
    end
    xfer(6'd7, 1'b0, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "abort_rd");
  endtask

  task automatic test_sel_zero();
    xfer(6'd3, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, ERR_EN, 1'b0, "sel0_wr");
    xfer(6'd3, 1'b0, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, "sel0_rd");
  endtask

  task automatic test_back_to_back();
    int n, acks, first, second;
    logic [31:0] exp;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h11BB33DD);
    bus.wb_adr_i = 6'd3;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0; acks = 0; first = 0; second = 0;
    while (n < 20 && acks < 2) begin
      @(posedge wb_clk); #1;
      n++;
      if (bus.wb_ack_o === 1'b1) begin
        acks++;
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.wb_dat_o !== exp) begin
          n_bad++;
          $display("FAIL b2b_rdata%0d: got %h, required %h", acks, bus.wb_dat_o, exp);
        end
        if (acks == 1) begin
          first = n;
          bus.wb_adr_i = 6'd5;
        end else begin
          second = n;
        end
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    n_cmp++;
    if (acks != 2) begin
      n_bad++;
      $display("FAIL b2b_timeout: got %0d acks, required 2", acks);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (first != WS + 1 || second - first != WS + 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: first %0d gap %0d, required %0d and %0d", first, second - first, WS + 1, WS + 2);
    end
    @(posedge wb_clk); #1;
  endtask

  task automatic test_reset_mid();
    int s0;
    xfer(CTRL, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, "rm_pre_start");
    pulse_done();
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h2, 1'b0, 1'b0, "rm_pre_stat");
    s0 = start_cycles;
    bus.wb_adr_i = CTRL;
    bus.wb_dat_i = 32'h1;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || dsp_start_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_async: ack=%b err=%b start=%b, required 0 0 0", bus.wb_ack_o, bus.wb_err_o, dsp_start_o);
    end
    repeat (2) @(posedge wb_clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    wb_rst = 1'b1;
    check_start_delta(s0, 0, "rm_no_pulse");
    xfer(CTRL, 1'b0, 32'd0, 4'hF, 32'h0, 1'b0, 1'b0, "rm_stat");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_start_done();
    test_start_while_busy();
    test_abort();
    test_sel_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
